// File: rtl/cs_y_buffer_if.sv
// Result stream between CS, this buffer and the downstream consumer.
// The slave side is the buffer; the master side drives Y/en and dout_ready.
interface cs_y_buffer_if #(
  parameter int WIDTH = 10
);
  logic             en;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport slave (
    input  en,
    input  Y,
    input  dout_ready,
    output dout,
    output dout_valid
  );

  modport master (
    output en,
    output Y,
    output dout_ready,
    input  dout,
    input  dout_valid
  );
endinterface

// File: rtl/cs_y_buffer.sv
// Captures CS results after its window fills, queues them in a FWFT FIFO and
// tracks occupancy, sticky overflow and a saturating drop count.
module cs_y_buffer #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 16,
  parameter int WARMUP = 8,
  parameter int CNTW   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  cs_y_buffer_if.slave           bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   warm,
  output logic                   ovf,
  output logic [CNTW-1:0]        drop_cnt
);
  localparam int PW   = $clog2(DEPTH);
  localparam int PTRW = PW + 1;
  localparam int WCW  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WCW-1:0]  WARM_TC  = WCW'(WARMUP);
  localparam logic [PTRW-1:0] FULL_LVL = PTRW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  rd;
  logic [PTRW-1:0]  wr;
  logic [WCW-1:0]   wcnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             do_write;
  logic             drop;

  // Pointers carry a wrap bit, so their difference is the occupancy 0..DEPTH.
  assign level    = wr - rd;
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign warm     = (wcnt == WARM_TC);
  assign push     = bus.en & warm;
  assign pop      = ~empty & bus.dout_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  assign bus.dout_valid = ~empty;
  assign bus.dout       = empty ? '0 : mem[rd[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt     <= '0;
      rd       <= '0;
      wr       <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (bus.en && !warm) wcnt <= wcnt + WCW'(1);
      if (do_write)        wr   <= wr + PTRW'(1);
      if (pop)             rd   <= rd + PTRW'(1);
      if (drop) begin
        ovf <= 1'b1;
        if (!(&drop_cnt)) drop_cnt <= drop_cnt + CNTW'(1);
      end
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (!reset && do_write) mem[wr[PW-1:0]] <= bus.Y;
  end
endmodule
